// File: rtl/conv_loop_controller.sv
// conv_loop_controller: sequences the 2D convolution loop nest for the MAC
// datapath. It issues one MAC step per accepted handshake, computes padded
// input coordinates, and delays output coordinates to line up with the
// accumulator result.
module conv_loop_controller #(
   parameter int ACTIVATIONS_WIDTH  = 64,
   parameter int ACTIVATIONS_HEIGHT = 64,
   parameter int INPUT_NB_CHANNELS  = 4,
   parameter int OUTPUT_NB_CHANNELS = 32,
   parameter int KERNEL_SIZE        = 3,
   parameter int PIPE_DEPTH         = 3,
   localparam int CIW = (INPUT_NB_CHANNELS  > 1) ? $clog2(INPUT_NB_CHANNELS)  : 1,
   localparam int COW = (OUTPUT_NB_CHANNELS > 1) ? $clog2(OUTPUT_NB_CHANNELS) : 1,
   localparam int KW  = (KERNEL_SIZE        > 1) ? $clog2(KERNEL_SIZE)        : 1,
   localparam int XW  = $clog2(ACTIVATIONS_WIDTH),
   localparam int YW  = $clog2(ACTIVATIONS_HEIGHT)
) (
   input  logic                  clk,
   input  logic                  rst_in,
   input  logic                  start,
   output logic                  running,
   output logic                  done,
   output logic                  step_valid,
   input  logic                  step_ready,
   output logic                  step_first,
   output logic                  step_last,
   output logic [CIW-1:0]        step_ch_in,
   output logic [KW-1:0]         step_kx,
   output logic [KW-1:0]         step_ky,
   output logic [COW-1:0]        step_ch_out,
   output logic signed [XW:0]    step_in_x,
   output logic signed [YW:0]    step_in_y,
   output logic                  step_pad,
   output logic                  output_valid,
   output logic [XW-1:0]         output_x,
   output logic [YW-1:0]         output_y,
   output logic [COW-1:0]        output_ch
);

   // Internal coordinate width wide enough that x+kx-K/2 never wraps, so the
   // pad decision is exact even when the narrower port value wraps.
   localparam int PW = ((XW > YW) ? XW : YW) + KW + 2;

   localparam logic [CIW-1:0] CI_MAX = CIW'(INPUT_NB_CHANNELS - 1);
   localparam logic [KW-1:0]  K_MAX  = KW'(KERNEL_SIZE - 1);
   localparam logic [COW-1:0] CO_MAX = COW'(OUTPUT_NB_CHANNELS - 1);
   localparam logic [XW-1:0]  X_MAX  = XW'(ACTIVATIONS_WIDTH - 1);
   localparam logic [YW-1:0]  Y_MAX  = YW'(ACTIVATIONS_HEIGHT - 1);
   localparam logic signed [PW-1:0] HALF_K = PW'(KERNEL_SIZE / 2);
   localparam logic signed [PW-1:0] W_S    = PW'(ACTIVATIONS_WIDTH);
   localparam logic signed [PW-1:0] H_S    = PW'(ACTIVATIONS_HEIGHT);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

   state_t            r_state;
   state_t            w_next;
   logic              r_running;
   logic              r_done;
   logic [CIW-1:0]    r_ch_in;
   logic [KW-1:0]     r_kx;
   logic [KW-1:0]     r_ky;
   logic [COW-1:0]    r_ch_out;
   logic [XW-1:0]     r_x;
   logic [YW-1:0]     r_y;
   logic              r_pipe_vld [PIPE_DEPTH];
   logic [XW-1:0]     r_pipe_x   [PIPE_DEPTH];
   logic [YW-1:0]     r_pipe_y   [PIPE_DEPTH];
   logic [COW-1:0]    r_pipe_ch  [PIPE_DEPTH];

   logic              w_accept;
   logic              w_c_ci, w_c_kx, w_c_ky, w_c_co, w_c_x, w_c_y;
   logic              w_pipe_busy;
   logic signed [PW-1:0] w_ix;
   logic signed [PW-1:0] w_iy;
   logic              w_pad;

   // Carry chain: each wN is "all counters up to and including N are at max"
   assign w_accept = (r_state == S_RUN) && step_ready;
   assign w_c_ci   = (r_ch_in == CI_MAX);
   assign w_c_kx   = w_c_ci && (r_kx == K_MAX);
   assign w_c_ky   = w_c_kx && (r_ky == K_MAX);
   assign w_c_co   = w_c_ky && (r_ch_out == CO_MAX);
   assign w_c_x    = w_c_co && (r_x == X_MAX);
   assign w_c_y    = w_c_x  && (r_y == Y_MAX);

   assign w_ix  = $signed({{(PW-XW){1'b0}}, r_x}) + $signed({{(PW-KW){1'b0}}, r_kx}) - HALF_K;
   assign w_iy  = $signed({{(PW-YW){1'b0}}, r_y}) + $signed({{(PW-KW){1'b0}}, r_ky}) - HALF_K;
   assign w_pad = (w_ix < 0) || (w_ix >= W_S) || (w_iy < 0) || (w_iy >= H_S);

   // Pipeline still holds a result that has not yet reached the last stage
   always_comb begin
      w_pipe_busy = 1'b0;
      for (int i = 0; i < PIPE_DEPTH - 1; i++) begin
         w_pipe_busy = w_pipe_busy | r_pipe_vld[i];
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst_in) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (start) w_next = S_RUN;
         S_RUN:   if (w_accept && w_c_y) w_next = S_DRAIN;
         S_DRAIN: if (!w_pipe_busy) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Registered protocol outputs: running follows the next state, done marks DRAIN->IDLE
   always_ff @(posedge clk) begin
      if (rst_in) begin
         r_running <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_running <= (w_next != S_IDLE);
         r_done    <= (r_state == S_DRAIN) && (w_next == S_IDLE);
      end
   end

   // Loop counters, innermost ch_in; they wrap back to zero after the final step
   always_ff @(posedge clk) begin
      if (rst_in) begin
         r_ch_in  <= '0;
         r_kx     <= '0;
         r_ky     <= '0;
         r_ch_out <= '0;
         r_x      <= '0;
         r_y      <= '0;
      end else if (w_accept) begin
         r_ch_in <= w_c_ci ? '0 : r_ch_in + CIW'(1);
         if (w_c_ci) r_kx     <= (r_kx == K_MAX)     ? '0 : r_kx + KW'(1);
         if (w_c_kx) r_ky     <= (r_ky == K_MAX)     ? '0 : r_ky + KW'(1);
         if (w_c_ky) r_ch_out <= (r_ch_out == CO_MAX) ? '0 : r_ch_out + COW'(1);
         if (w_c_co) r_x      <= (r_x == X_MAX)      ? '0 : r_x + XW'(1);
         if (w_c_x)  r_y      <= (r_y == Y_MAX)      ? '0 : r_y + YW'(1);
      end
   end

   // Output-coordinate delay line; free-running so it tracks the datapath, not the handshake
   always_ff @(posedge clk) begin
      if (rst_in) begin
         for (int i = 0; i < PIPE_DEPTH; i++) begin
            r_pipe_vld[i] <= 1'b0;
            r_pipe_x[i]   <= '0;
            r_pipe_y[i]   <= '0;
            r_pipe_ch[i]  <= '0;
         end
      end else begin
         r_pipe_vld[0] <= w_accept && w_c_ky;
         r_pipe_x[0]   <= r_x;
         r_pipe_y[0]   <= r_y;
         r_pipe_ch[0]  <= r_ch_out;
         for (int i = 1; i < PIPE_DEPTH; i++) begin
            r_pipe_vld[i] <= r_pipe_vld[i-1];
            r_pipe_x[i]   <= r_pipe_x[i-1];
            r_pipe_y[i]   <= r_pipe_y[i-1];
            r_pipe_ch[i]  <= r_pipe_ch[i-1];
         end
      end
   end

   // Output logic: step fields only driven in RUN so idle outputs read as zero
   always_comb begin
      step_valid  = 1'b0;
      step_first  = 1'b0;
      step_last   = 1'b0;
      step_ch_in  = '0;
      step_kx     = '0;
      step_ky     = '0;
      step_ch_out = '0;
      step_in_x   = '0;
      step_in_y   = '0;
      step_pad    = 1'b0;
      if (r_state == S_RUN) begin
         step_valid  = 1'b1;
         step_first  = (r_ch_in == '0) && (r_kx == '0) && (r_ky == '0);
         step_last   = w_c_ky;
         step_ch_in  = r_ch_in;
         step_kx     = r_kx;
         step_ky     = r_ky;
         step_ch_out = r_ch_out;
         step_in_x   = w_ix[XW:0];
         step_in_y   = w_iy[YW:0];
         step_pad    = w_pad;
      end
   end

   assign running      = r_running;
   assign done         = r_done;
   assign output_valid = r_pipe_vld[PIPE_DEPTH-1];
   assign output_x     = r_pipe_x[PIPE_DEPTH-1];
   assign output_y     = r_pipe_y[PIPE_DEPTH-1];
   assign output_ch    = r_pipe_ch[PIPE_DEPTH-1];

endmodule

// File: tb/tb_conv_loop_controller.sv
// Testbench for conv_loop_controller: W=H=4, CIN=2, COUT=2, K=3, PIPE_DEPTH=3
// main instance plus a K=1, CIN=1 degenerate instance.
module tb_conv_loop_controller;

   logic clk = 1'b0;
   logic rst_in, start, step_ready;
   logic running, done, step_valid, step_first, step_last, step_pad, output_valid;
   logic [0:0] step_ch_in, step_ch_out, output_ch;
   logic [1:0] step_kx, step_ky, output_x, output_y;
   logic signed [2:0] step_in_x, step_in_y;

   logic start2, ready2;
   logic running2, done2, sv2, first2, last2, pad2, ov2;
   logic [0:0] ci2, co2, och2, kx2, ky2;
   logic [1:0] ox2, oy2;
   logic signed [2:0] ix2, iy2;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   bit rnd_ready = 1'b0;
   bit mon_clr = 1'b0;
   int start_cyc = 0;

   // monitor state
   int acc_cnt, out_cnt, done_cnt, done_cyc, pad_cnt;
   int seq_err, stall_err, lat_err, out_err;
   int run_rise, run_fall, first_out_cyc;
   int rec_in_x [576];
   int rec_in_y [576];
   int rec_pad  [576];
   int acc_cyc  [576];
   int lastq [$];

   typedef struct {
      int x, y, kx, ky;
      int exp_in_x, exp_in_y, exp_pad;
   } pad_vec_t;
   pad_vec_t pvec [5];

   logic [14:0] w_fields;
   assign w_fields = {step_first, step_last, step_ch_in, step_kx, step_ky, step_ch_out,
                      step_in_x, step_in_y, step_pad};

   conv_loop_controller #(
      .ACTIVATIONS_WIDTH(4), .ACTIVATIONS_HEIGHT(4), .INPUT_NB_CHANNELS(2),
      .OUTPUT_NB_CHANNELS(2), .KERNEL_SIZE(3), .PIPE_DEPTH(3)
   ) dut (
      .clk(clk), .rst_in(rst_in), .start(start), .running(running), .done(done),
      .step_valid(step_valid), .step_ready(step_ready), .step_first(step_first),
      .step_last(step_last), .step_ch_in(step_ch_in), .step_kx(step_kx), .step_ky(step_ky),
      .step_ch_out(step_ch_out), .step_in_x(step_in_x), .step_in_y(step_in_y),
      .step_pad(step_pad), .output_valid(output_valid), .output_x(output_x),
      .output_y(output_y), .output_ch(output_ch)
   );

   conv_loop_controller #(
      .ACTIVATIONS_WIDTH(4), .ACTIVATIONS_HEIGHT(4), .INPUT_NB_CHANNELS(1),
      .OUTPUT_NB_CHANNELS(2), .KERNEL_SIZE(1), .PIPE_DEPTH(3)
   ) dut2 (
      .clk(clk), .rst_in(rst_in), .start(start2), .running(running2), .done(done2),
      .step_valid(sv2), .step_ready(ready2), .step_first(first2),
      .step_last(last2), .step_ch_in(ci2), .step_kx(kx2), .step_ky(ky2),
      .step_ch_out(co2), .step_in_x(ix2), .step_in_y(iy2),
      .step_pad(pad2), .output_valid(ov2), .output_x(ox2),
      .output_y(oy2), .output_ch(och2)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // step_ready driver
   initial begin
      step_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         step_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Monitor: checks every accepted step against an index-decomposition model
   initial begin : monitor
      int i, ci, kx, ky, co, x, y, ix, iy, pd, fi, la, o, lc;
      bit prev_stall, prev_run;
      logic [14:0] saved;
      prev_stall = 1'b0;
      prev_run = 1'b0;
      saved = '0;
      forever begin
         @(negedge clk);
         if (mon_clr) begin
            acc_cnt = 0; out_cnt = 0; done_cnt = 0; done_cyc = -1; pad_cnt = 0;
            seq_err = 0; stall_err = 0; lat_err = 0; out_err = 0;
            run_rise = -1; run_fall = -1; first_out_cyc = -1;
            lastq.delete();
            prev_stall = 1'b0;
         end else begin
            if (prev_stall && (!step_valid || w_fields !== saved)) stall_err++;
            prev_stall = step_valid && !step_ready;
            saved = w_fields;
            if (step_valid && step_ready) begin
               i  = acc_cnt;
               ci = i % 2;
               kx = (i / 2) % 3;
               ky = (i / 6) % 3;
               co = (i / 18) % 2;
               x  = (i / 36) % 4;
               y  = (i / 144) % 4;
               ix = x + kx - 1;
               iy = y + ky - 1;
               pd = (ix < 0 || ix > 3 || iy < 0 || iy > 3) ? 1 : 0;
               fi = (ci == 0 && kx == 0 && ky == 0) ? 1 : 0;
               la = (ci == 1 && kx == 2 && ky == 2) ? 1 : 0;
               if (int'(step_ch_in) != ci || int'(step_kx) != kx || int'(step_ky) != ky ||
                   int'(step_ch_out) != co || int'(step_first) != fi || int'(step_last) != la ||
                   (int'(step_in_x) & 7) != (ix & 7) || (int'(step_in_y) & 7) != (iy & 7) ||
                   int'(step_pad) != pd) begin
                  if (seq_err == 0) $display("step %0d differs from loop-order model", i);
                  seq_err++;
               end
               if (i < 576) begin
                  rec_in_x[i] = int'(step_in_x);
                  rec_in_y[i] = int'(step_in_y);
                  rec_pad[i]  = int'(step_pad);
                  acc_cyc[i]  = cyc;
               end
               if (step_pad) pad_cnt++;
               if (step_last) lastq.push_back(cyc);
               acc_cnt++;
            end
            if (output_valid) begin
               o = out_cnt;
               if (int'(output_ch) != o % 2 || int'(output_x) != (o / 2) % 4 ||
                   int'(output_y) != (o / 8) % 4) out_err++;
               if (lastq.size() == 0) lat_err++;
               else begin
                  lc = lastq.pop_front();
                  if (cyc != lc + 3) lat_err++;
               end
               if (out_cnt == 0) first_out_cyc = cyc;
               out_cnt++;
            end
            if (done) begin
               done_cnt++;
               done_cyc = cyc;
            end
            if (running && !prev_run) run_rise = cyc;
            if (!running && prev_run) run_fall = cyc;
         end
         prev_run = running;
      end
   end

   task automatic clear_mon();
      mon_clr = 1'b1;
      @(posedge clk);
      #1;
      mon_clr = 1'b0;
   endtask

   task automatic run_layer(input bit rnd, input bit poke, input string tag);
      rnd_ready = rnd;
      clear_mon();
      start = 1'b1;
      start_cyc = cyc;
      @(posedge clk); #1;
      start = 1'b0;
      if (poke) begin
         repeat (100) @(posedge clk);
         #1 start = 1'b1;
         @(posedge clk); #1;
         start = 1'b0;
         repeat (476) @(posedge clk);
         #1 start = 1'b1;
         @(posedge clk); #1;
         start = 1'b0;
      end
      for (int k = 0; k < 6000 && done_cnt == 0; k++) @(posedge clk);
      rnd_ready = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      chk({tag, "_steps"}, acc_cnt, 576);
      chk({tag, "_outputs"}, out_cnt, 32);
      chk({tag, "_done_pulses"}, done_cnt, 1);
      chk({tag, "_step_seq_errs"}, seq_err, 0);
      chk({tag, "_stall_errs"}, stall_err, 0);
      chk({tag, "_out_coord_errs"}, out_err, 0);
      chk({tag, "_out_latency_errs"}, lat_err, 0);
      chk({tag, "_pad_steps"}, pad_cnt, 176);
      chk({tag, "_running_rise"}, run_rise - start_cyc, 1);
      chk({tag, "_running_fall_at_done"}, run_fall, done_cyc);
      if (!rnd) chk({tag, "_done_latency"}, done_cyc - start_cyc, 580);
   endtask

   initial begin : main
      int snap_done, snap_out, n2, fl2, p2, o2, s2c, d2c;
      pvec[0] = '{0, 0, 0, 0, -1, -1, 1};
      pvec[1] = '{3, 3, 2, 2,  4,  4, 1};
      pvec[2] = '{1, 1, 1, 1,  1,  1, 0};
      pvec[3] = '{3, 0, 1, 0,  3, -1, 1};
      pvec[4] = '{2, 3, 2, 1,  3,  3, 0};

      rst_in = 1'b1; start = 1'b0; start2 = 1'b0; ready2 = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_step_valid", int'(step_valid), 0);
      chk("rst_running", int'(running), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_output_valid", int'(output_valid), 0);
      chk("rst_step_pad", int'(step_pad), 0);
      chk("rst_step_in_x", int'(step_in_x), 0);
      @(posedge clk); #1;
      rst_in = 1'b0;
      repeat (2) @(posedge clk); #1;

      // basic run with step_ready tied high
      run_layer(1'b0, 1'b0, "basic");
      chk("first_output_after_step18", first_out_cyc - acc_cyc[17], 3);
      for (int v = 0; v < 5; v++) begin
         int idx;
         idx = ((((pvec[v].y * 4 + pvec[v].x) * 2) * 3 + pvec[v].ky) * 3 + pvec[v].kx) * 2;
         chk($sformatf("pad_vec%0d_in_x_mod8", v), rec_in_x[idx] & 7, pvec[v].exp_in_x & 7);
         chk($sformatf("pad_vec%0d_in_y_mod8", v), rec_in_y[idx] & 7, pvec[v].exp_in_y & 7);
         chk($sformatf("pad_vec%0d_pad", v), rec_pad[idx], pvec[v].exp_pad);
      end

      // random back-pressure
      run_layer(1'b1, 1'b0, "stall");

      // start pulses during RUN and DRAIN
      run_layer(1'b0, 1'b1, "restart");

      // reset part-way through a layer
      rnd_ready = 1'b0;
      clear_mon();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int k = 0; k < 2000 && acc_cnt < 200; k++) @(posedge clk);
      #1 rst_in = 1'b1;
      @(posedge clk); #1;
      rst_in = 1'b0;
      @(negedge clk);
      chk("midrst_step_valid", int'(step_valid), 0);
      chk("midrst_running", int'(running), 0);
      chk("midrst_output_valid", int'(output_valid), 0);
      chk("midrst_step_first", int'(step_first), 0);
      chk("midrst_output_x", int'(output_x), 0);
      snap_done = done_cnt;
      snap_out = out_cnt;
      repeat (20) @(negedge clk);
      chk("midrst_no_done", done_cnt, snap_done);
      chk("midrst_no_output", out_cnt, snap_out);
      @(posedge clk); #1;
      run_layer(1'b0, 1'b0, "after_rst");

      // degenerate K=1, CIN=1 instance
      n2 = 0; fl2 = 0; p2 = 0; o2 = 0; d2c = -1;
      @(posedge clk); #1;
      start2 = 1'b1;
      s2c = cyc;
      @(posedge clk); #1;
      start2 = 1'b0;
      for (int k = 0; k < 300 && d2c < 0; k++) begin
         @(negedge clk);
         if (sv2) n2++;
         if (sv2 && first2 && last2) fl2++;
         if (sv2 && pad2) p2++;
         if (ov2) o2++;
         if (done2) d2c = cyc;
      end
      chk("k1_steps", n2, 32);
      chk("k1_first_and_last", fl2, 32);
      chk("k1_pad", p2, 0);
      chk("k1_outputs", o2, 32);
      chk("k1_done_latency", d2c - s2c, 36);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
